// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg
//   Shared types and helpers for the parallel-to-serial feeder.
//   - state_e  : shifter control states (IDLE, SHIFT)
//   - cntWidth : number of bits needed to hold a bit index 0..width-1
package bit_serializer_pkg;

  // IDLE: nothing in the shifter, bit_o shows the idle level.
  // SHIFT: the shifter holds a word and bit_o shows its MSB.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bit index counter width for a word of 'width' bits. Legal widths
  // start at 2, so the result is always at least 1.
  function automatic int unsigned cntWidth(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/word_hold_buf.sv
// word_hold_buf
//   Single-entry parking register for one parallel word. It lets the
//   serializer accept the next word while the current one is still
//   being shifted, so consecutive words stream out without a gap.
//
// Ports
//   clk_i     : clock, rising edge
//   reset_i   : synchronous active-high reset, empties the buffer
//   wr_en_i   : capture data_i and mark the buffer full
//   clr_en_i  : the shifter has taken the stored word, mark empty
//   data_i    : word to store
//   full_o    : buffer currently holds a word
//   data_o    : stored word
module word_hold_buf
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic             clr_en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // A write only happens while the buffer is empty and a clear only
  // while it is full, so the two enables are mutually exclusive; the
  // write branch is listed first purely for determinism.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (wr_en_i) begin
      r_full <= 1'b1;
      r_data <= data_i;
    end else if (clr_en_i) begin
      r_full <= 1'b0;
    end
  end

  // The parent gates writes with ready_o (buffer empty) and clears with
  // buffer full, so both on one edge means a control bug upstream.
  a_noWriteAndClear : assert property (
    @(posedge clk_i) disable iff (reset_i) !(wr_en_i && clr_en_i)
  );

  assign full_o = r_full;
  assign data_o = r_data;

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer
//   Converts parallel words received on a valid/ready handshake into a
//   single-bit stream, MSB first, one bit per cycle in which the
//   consumer asserts enable_i. A one-entry holding buffer lets the next
//   word be accepted while the current one is shifting, so back-to-back
//   words produce a contiguous stream.
//
// Ports
//   clk_i       : clock, rising edge
//   reset_i     : synchronous active-high reset; discards any partial word
//   data_i      : parallel word, sampled when valid_i && ready_o
//   valid_i     : data_i holds a word
//   ready_o     : a word can be accepted this cycle (holding buffer empty)
//   enable_i    : consumer takes the current bit this cycle
//   bit_o       : current serial bit (IDLE_BIT when nothing is shifting)
//   bit_valid_o : bit_o carries word data
//   first_o     : bit_o is the MSB of a word
//   last_o      : bit_o is the LSB of a word
//   busy_o      : shifter or holding buffer occupied
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             enable_i,
  output logic             bit_o,
  output logic             bit_valid_o,
  output logic             first_o,
  output logic             last_o,
  output logic             busy_o
);

  localparam int unsigned      CNT_W   = cntWidth(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_count;

  logic             r_bit;
  logic             r_bitValid;
  logic             r_first;
  logic             r_last;
  logic             r_busy;

  state_e           w_stateNext;
  logic [WIDTH-1:0] w_shiftNext;
  logic [CNT_W-1:0] w_countNext;

  logic             w_holdWr;
  logic             w_holdClr;
  logic             w_holdFull;
  logic             w_holdFullNext;
  logic [WIDTH-1:0] w_holdData;

  logic             w_ready;
  logic             w_accept;
  logic             w_consume;
  logic             w_lastConsume;

  // ready_o depends only on registered state so it never forms a
  // combinational path from valid_i.
  assign w_ready       = !w_holdFull;
  assign w_accept      = valid_i && w_ready;
  assign w_consume     = (r_state == SHIFT) && enable_i;
  assign w_lastConsume = w_consume && (r_count == '0);

  word_hold_buf #(
    .WIDTH (WIDTH)
  ) u_holdBuf (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .wr_en_i  (w_holdWr),
    .clr_en_i (w_holdClr),
    .data_i   (data_i),
    .full_o   (w_holdFull),
    .data_o   (w_holdData)
  );

  // Occupancy of the holding buffer after this edge; feeds the
  // registered busy flag so busy_o stays aligned with the buffer.
  assign w_holdFullNext = w_holdWr || (w_holdFull && !w_holdClr);

  // Next-state logic. When the last bit of a word is consumed the
  // shifter reloads on the same edge, preferring the parked word over a
  // fresh accept, which keeps the stream gap-free and in order. An
  // accept that is not loaded straight into the shifter is parked.
  always_comb begin
    w_stateNext = r_state;
    w_shiftNext = r_shift;
    w_countNext = r_count;
    w_holdWr    = 1'b0;
    w_holdClr   = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_shiftNext = data_i;
          w_countNext = CNT_MAX;
          w_stateNext = SHIFT;
        end
      end

      SHIFT: begin
        if (w_lastConsume) begin
          if (w_holdFull) begin
            w_shiftNext = w_holdData;
            w_countNext = CNT_MAX;
            w_holdClr   = 1'b1;
          end else if (w_accept) begin
            w_shiftNext = data_i;
            w_countNext = CNT_MAX;
          end else begin
            w_stateNext = IDLE;
          end
        end else if (w_consume) begin
          w_shiftNext = {r_shift[WIDTH-2:0], 1'b0};
          w_countNext = r_count - CNT_W'(1);
        end

        if (w_accept && !w_lastConsume) begin
          w_holdWr = 1'b1;
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State and output registers. Outputs are computed from the next-state
  // values so they are true flops yet describe the current shifter
  // contents; with enable_i low nothing changes and they hold steady.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_count    <= '0;
      r_bit      <= IDLE_BIT;
      r_bitValid <= 1'b0;
      r_first    <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_shift    <= w_shiftNext;
      r_count    <= w_countNext;
      r_bit      <= (w_stateNext == SHIFT) ? w_shiftNext[WIDTH-1] : IDLE_BIT;
      r_bitValid <= (w_stateNext == SHIFT);
      r_first    <= (w_stateNext == SHIFT) && (w_countNext == CNT_MAX);
      r_last     <= (w_stateNext == SHIFT) && (w_countNext == '0);
      r_busy     <= (w_stateNext == SHIFT) || w_holdFullNext;
    end
  end

  assign ready_o     = w_ready;
  assign bit_o       = r_bit;
  assign bit_valid_o = r_bitValid;
  assign first_o     = r_first;
  assign last_o      = r_last;
  assign busy_o      = r_busy;

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Upstream feeder for the 2-bit-output serial state machine: converts parallel words into the single-bit stream that drives that machine's `in_i` input.
- Words arrive over a valid/ready handshake and are shifted out MSB-first, one bit per consumed cycle.
- A one-entry holding buffer allows back-to-back words with no gap in the bit stream.
- An advance enable lets the consumer pause the stream.

Parameters:
- WIDTH, 8, bits per parallel word; legal range 2..32.
- IDLE_BIT, 1'b0, value driven on bit_o when no word is being shifted.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_i  input  1  synchronous active-high reset.
- data_i  input  WIDTH  parallel word; sampled when valid_i && ready_o.
- valid_i  input  1  data_i holds a word.
- ready_o  output  1  block can accept a word this cycle.
- enable_i  input  1  consumer takes the current bit this cycle.
- bit_o  output  1  current serial bit; connects to downstream in_i.
- bit_valid_o  output  1  bit_o carries word data.
- first_o  output  1  bit_o is bit WIDTH-1 (MSB) of a word.
- last_o  output  1  bit_o is bit 0 (LSB) of a word.
- busy_o  output  1  shifter or holding buffer occupied.

Behaviour:
- Reset: clk_i with reset_i=1 synchronously clears everything; asserting reset_i mid-word discards the shifter and holding buffer, with no partial word resumed.
  - state=IDLE, bit count=0, holding buffer empty.
  - Outputs: bit_o=IDLE_BIT, bit_valid_o=0, first_o=0, last_o=0, busy_o=0, ready_o=1.
- Handshake:
  - Accept on an edge where valid_i && ready_o.
  - ready_o = !hold_full; combinational from registered state only, never from valid_i.
  - valid_i may be held while ready_o=0; data_i must stay stable until accepted.
- States (enum): IDLE, SHIFT.
  - IDLE: accepted word loads directly into the shifter; count=WIDTH-1; next state SHIFT. bit_o = MSB from the following cycle, giving 1-cycle latency from accept to first bit.
  - SHIFT: a bit is consumed on a cycle with bit_valid_o && enable_i. Consumption shifts the register left by one and decrements count.
  - Last bit consumed (count==0 && enable_i): if the holding buffer is full, load it into the shifter on the same edge, count=WIDTH-1, stay in SHIFT, and mark the buffer empty.
  - Last bit consumed, holding buffer empty, same-cycle accept (valid_i && ready_o): load data_i into the shifter and stay in SHIFT. The stream has no gap.
  - Last bit consumed, otherwise: go to IDLE.
  - Accept in SHIFT when the shifter does not reload on that edge: data_i goes to the holding buffer.
  - Accept and reload on the same edge with a full buffer: cannot occur, because ready_o=0.
- Pause: enable_i=0 freezes shifter, count and outputs.
  - bit_valid_o stays 1 and bit_o stays unchanged.
  - Accepts into the holding buffer still occur.
- Outputs, all registered except ready_o:
  - bit_o = shifter MSB in SHIFT, else IDLE_BIT.
  - bit_valid_o = (state==SHIFT).
  - first_o = SHIFT && count==WIDTH-1.
  - last_o = SHIFT && count==0.
  - busy_o = (state==SHIFT) || hold_full.
- Widths:
  - Count is CNT_W = $clog2(WIDTH) bits, unsigned.
  - Count never wraps; reload always sets WIDTH-1.
  - enable_i in IDLE is ignored.

Decomposition:
- Package bit_serializer_pkg: state enum typedef (IDLE, SHIFT); a function returning CNT_W for a given WIDTH.
- One sub-module: word_hold_buf, a single-entry WIDTH-bit register.
  - Ports: write enable, read/clear enable, full flag, data out.
  - Simultaneous write and clear never occurs (guarded by ready_o); the sub-module asserts this in simulation.

Test Plan:
- Single word (WIDTH=8): data_i=8'hA5 accepted at edge t, enable_i=1 throughout -> bit_o over t+1..t+8 = 1,0,1,0,0,1,0,1; first_o at t+1 only; last_o at t+8 only; IDLE with bit_o=0 and busy_o=0 at t+9.
- Back-to-back: 8'hA5 at t, 8'h3C offered from t+1 -> 8'h3C accepted into holding buffer at t+1, ready_o=0 from t+2 to t+8, ready_o=1 again at t+9. 16 contiguous bits: 10100101 then 00111100. last_o at t+8, first_o at t+9.
- Pause: 8'hF0 at t, enable_i=0 during t+3..t+5 -> bit_o frozen at 1 with bit_valid_o=1 for those cycles; remaining bits resume in order; last_o at t+11.
- Backpressure: three words 8'h01, 8'h02, 8'h03 offered with valid_i held -> third word stalls with ready_o=0 until 8'h01 finishes; output = 01,02,03 in order with no bit lost or duplicated.
- Reset mid-word: 8'hFF at t, reset_i=1 at edge t+4 -> from t+5 bit_o=0, bit_valid_o=0, ready_o=1, busy_o=0. New word 8'h81 afterwards -> clean 1,0,0,0,0,0,0,1.
- Idle value: IDLE_BIT=1, no valid_i for 10 cycles -> bit_o=1 and bit_valid_o=0 throughout.
